// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: IF and LS requester handshakes plus the shared memory port.
// The slave modport is the arbiter's view; the master modport is the surrounding core/memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_resp_valid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  ls_req_valid;
    logic                  ls_req_ready;
    logic [ADDR_W-1:0]     ls_addr;
    logic                  ls_wen;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_wmask;
    logic                  ls_resp_valid;
    logic [DATA_W-1:0]     ls_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req_valid, if_addr, ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
               mem_req_ready, mem_resp_valid, mem_rdata,
        output if_req_ready, if_resp_valid, if_rdata, ls_req_ready, ls_resp_valid, ls_rdata,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output if_req_valid, if_addr, ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
               mem_req_ready, mem_resp_valid, mem_rdata,
        input  if_req_ready, if_resp_valid, if_rdata, ls_req_ready, ls_resp_valid, ls_rdata,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and load/store, one transaction in flight.
// Define MEM_PORT_ARBITER_RR_EN for round-robin arbitration; default is fixed priority LS over IF.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

    state_t              state, state_nxt;
    owner_t              owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   if_rdata_q, ls_rdata_q;
    logic                grant_if, grant_ls;
    logic                resp_fire;
    logic                accept;

`ifdef MEM_PORT_ARBITER_RR_EN
    owner_t last_grant;

    // On contention the requester that was not granted last time wins.
    always_comb begin
        grant_ls = bus.ls_req_valid && (!bus.if_req_valid || last_grant == OWN_IF);
        grant_if = bus.if_req_valid && !grant_ls;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_IF;
        end else if (accept) begin
            last_grant <= grant_ls ? OWN_LS : OWN_IF;
        end
    end
`else
    assign grant_ls = bus.ls_req_valid;
    assign grant_if = bus.if_req_valid && !bus.ls_req_valid;
`endif

    assign accept = (state == IDLE) && (grant_if || grant_ls);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.if_req_ready  = 1'b0;
        bus.ls_req_ready  = 1'b0;
        bus.mem_req_valid = 1'b0;
        resp_fire         = 1'b0;
        case (state)
            IDLE: begin
                bus.if_req_ready = grant_if;
                bus.ls_req_ready = grant_ls;
                if (grant_if || grant_ls) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    resp_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches and read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (accept && grant_ls) begin
                owner   <= OWN_LS;
                addr_q  <= bus.ls_addr;
                wen_q   <= bus.ls_wen;
                wdata_q <= bus.ls_wdata;
                wmask_q <= bus.ls_wmask;
            end else if (accept) begin
                owner   <= OWN_IF;
                addr_q  <= bus.if_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
            if (bus.if_resp_valid) begin
                if_rdata_q <= bus.mem_rdata;
            end
            if (bus.ls_resp_valid) begin
                ls_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.if_resp_valid = resp_fire && (owner == OWN_IF);
    assign bus.ls_resp_valid = resp_fire && (owner == OWN_LS);
    // Read data flows through on the strobe cycle, then holds the captured copy.
    assign bus.if_rdata      = bus.if_resp_valid ? bus.mem_rdata : if_rdata_q;
    assign bus.ls_rdata      = bus.ls_resp_valid ? bus.mem_rdata : ls_rdata_q;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    string phase = "reset";

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Transaction-level reference: one outstanding transaction that is
    // either waiting for the memory to take it or waiting for its response.
    bit          m_busy    = 1'b0;
    bit          m_taken   = 1'b0;
    bit          m_last_ls = 1'b0;
    bit          t_own_ls;
    logic [63:0] t_addr;
    logic [63:0] t_wdata;
    bit          t_wen;
    logic [7:0]  t_wmask;
    bit          seen_grants[$];

    function automatic bit pick_ls(bit ifv, bit lsv);
`ifdef MEM_PORT_ARBITER_RR_EN
        if (ifv && lsv) return !m_last_ls;
`endif
        return lsv;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit          ifv, lsv, lsw, mrdy, mresp, rst_s, g_ls, g_if;
        logic [63:0] ifa, lsa, lsd, mrd;
        logic [7:0]  lsm;
        @(negedge clk);
        ifv = bus.if_req_valid;  lsv = bus.ls_req_valid;  lsw = bus.ls_wen;
        ifa = bus.if_addr;       lsa = bus.ls_addr;       lsd = bus.ls_wdata;
        lsm = bus.ls_wmask;      mrdy = bus.mem_req_ready;
        mresp = bus.mem_resp_valid; mrd = bus.mem_rdata;  rst_s = rst;
        g_ls = 1'b0;
        g_if = 1'b0;
        if (!m_busy) begin
            g_ls = pick_ls(ifv, lsv);
            g_if = ifv && !g_ls;
        end
        if (bus.ls_req_ready && lsv) seen_grants.push_back(1'b1);
        if (bus.if_req_ready && ifv) seen_grants.push_back(1'b0);
        chk("if_req_ready", bus.if_req_ready, g_if);
        chk("ls_req_ready", bus.ls_req_ready, g_ls);
        chk("mem_req_valid", bus.mem_req_valid, m_busy && !m_taken);
        chk("if_resp_valid", bus.if_resp_valid, m_busy && m_taken && mresp && !t_own_ls);
        chk("ls_resp_valid", bus.ls_resp_valid, m_busy && m_taken && mresp && t_own_ls);
        if (m_busy && !m_taken) begin
            chk("mem_addr", bus.mem_addr, t_addr);
            chk("mem_wen", bus.mem_wen, t_wen);
            chk("mem_wmask", bus.mem_wmask, t_wmask);
            if (t_own_ls) chk("mem_wdata", bus.mem_wdata, t_wdata);
        end
        if (m_busy && m_taken && mresp) begin
            if (t_own_ls) chk("ls_rdata", bus.ls_rdata, mrd);
            else          chk("if_rdata", bus.if_rdata, mrd);
        end
        @(posedge clk);
        if (rst_s) begin
            m_busy    = 1'b0;
            m_taken   = 1'b0;
            m_last_ls = 1'b0;
        end else if (!m_busy) begin
            if (g_ls || g_if) begin
                m_busy    = 1'b1;
                m_taken   = 1'b0;
                t_own_ls  = g_ls;
                m_last_ls = g_ls;
                t_addr    = g_ls ? lsa : ifa;
                t_wen     = g_ls ? lsw : 1'b0;
                t_wdata   = lsd;
                t_wmask   = g_ls ? lsm : 8'h00;
            end
        end else if (!m_taken) begin
            if (mrdy) m_taken = 1'b1;
        end else if (mresp) begin
            m_busy = 1'b0;
        end
        #1;
    endtask

    initial begin
        bus.if_req_valid   = 1'b0;
        bus.if_addr        = '0;
        bus.ls_req_valid   = 1'b0;
        bus.ls_addr        = '0;
        bus.ls_wen         = 1'b0;
        bus.ls_wdata       = '0;
        bus.ls_wmask       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        phase = "if_read";
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 64'h8000_0000;
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.if_req_valid = 1'b0;
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h13;
        cycle();
        bus.mem_resp_valid = 1'b0;
        cycle();

        phase = "simultaneous";
        seen_grants.delete();
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 64'h8000_0004;
        bus.ls_req_valid = 1'b1;
        bus.ls_addr      = 64'h8000_1000;
        bus.ls_wen       = 1'b1;
        bus.ls_wdata     = 64'hDEAD_BEEF;
        bus.ls_wmask     = 8'hFF;
        cycle();
        bus.ls_req_valid = 1'b0;
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0123_4567_89AB_CDEF;
        cycle();
        bus.mem_resp_valid = 1'b0;
        cycle();
        bus.if_req_valid = 1'b0;
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0000_0000_0000_0093;
        cycle();
        bus.mem_resp_valid = 1'b0;
        chk("grant_count", seen_grants.size(), 2);
        if (seen_grants.size() == 2) begin
            chk("first_grant_ls", seen_grants[0], 1'b1);
            chk("second_grant_ls", seen_grants[1], 1'b0);
        end

        phase = "backpressure";
        bus.mem_req_ready = 1'b0;
        bus.ls_req_valid  = 1'b1;
        bus.ls_addr       = 64'h8000_2000;
        bus.ls_wdata      = 64'hCAFE_F00D_1234_5678;
        bus.ls_wmask      = 8'h0F;
        cycle();
        bus.ls_req_valid = 1'b0;
        bus.if_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ls_addr = {$urandom, $urandom};
            cycle();
        end
        bus.if_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        cycle();
        bus.mem_resp_valid = 1'b1;
        cycle();
        bus.mem_resp_valid = 1'b0;
        cycle();

        phase = "reset_in_wait";
        bus.ls_req_valid = 1'b1;
        bus.ls_wen       = 1'b0;
        bus.ls_addr      = 64'h8000_3000;
        cycle();
        bus.ls_req_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        cycle();
        bus.mem_resp_valid = 1'b0;
        bus.if_req_valid   = 1'b1;
        bus.if_addr        = 64'h8000_0040;
        cycle();
        bus.if_req_valid = 1'b0;
        cycle();
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0000_0000_0010_0073;
        cycle();
        bus.mem_resp_valid = 1'b0;

        phase = "stray_resp";
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        cycle();
        bus.mem_resp_valid = 1'b0;
        cycle();

        phase = "contention";
        seen_grants.delete();
        bus.if_req_valid   = 1'b1;
        bus.ls_req_valid   = 1'b1;
        bus.ls_wen         = 1'b1;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.mem_rdata = {$urandom, $urandom};
            cycle();
        end
        bus.if_req_valid   = 1'b0;
        bus.ls_req_valid   = 1'b0;
        bus.mem_resp_valid = 1'b0;
        chk("contend_count", seen_grants.size(), 4);
        if (seen_grants.size() == 4) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            chk("contend_g0", seen_grants[0], 1'b1);
            chk("contend_g1", seen_grants[1], 1'b0);
            chk("contend_g2", seen_grants[2], 1'b1);
            chk("contend_g3", seen_grants[3], 1'b0);
`else
            chk("contend_g0", seen_grants[0], 1'b1);
            chk("contend_g1", seen_grants[1], 1'b1);
            chk("contend_g2", seen_grants[2], 1'b1);
            chk("contend_g3", seen_grants[3], 1'b1);
`endif
        end
        cycle();

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            rst                = ($urandom_range(0, 59) == 0);
            bus.if_req_valid   = 1'($urandom_range(0, 1));
            bus.if_addr        = {$urandom, $urandom};
            bus.ls_req_valid   = 1'($urandom_range(0, 1));
            bus.ls_addr        = {$urandom, $urandom};
            bus.ls_wen         = 1'($urandom_range(0, 1));
            bus.ls_wdata       = {$urandom, $urandom};
            bus.ls_wmask       = 8'($urandom);
            bus.mem_req_ready  = 1'($urandom_range(0, 1));
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_rdata      = {$urandom, $urandom};
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
